// File: rtl/command_fetch.sv
// Command fetch stage: owns the command PC, reads one 32-bit word per fetch from
// the memory bus and presents it to the parser through a valid/ready handshake.
module command_fetch #(
    parameter int                   ADDR_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = {ADDR_BITS{1'b0}},
    parameter int                   TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 jump_en,
    input  logic [ADDR_BITS-1:0] jump_addr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [31:0]          mem_data,
    input  logic                 mem_ack,
    output logic [31:0]          command_word,
    output logic [ADDR_BITS-1:0] cmd_pc,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 fetch_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic [31:0]            command_word_q, command_word_d;
    logic [ADDR_BITS-1:0]   cmd_pc_q, cmd_pc_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   fetch_err_q, fetch_err_d;
    logic [TW-1:0]          timer_q, timer_d;

    // Next-state and output logic; a jump overrides everything, including a same-cycle ack.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        mem_addr_d     = mem_addr_q;
        mem_rd_d       = mem_rd_q;
        command_word_d = command_word_q;
        cmd_pc_d       = cmd_pc_q;
        cmd_valid_d    = cmd_valid_q;
        fetch_err_d    = fetch_err_q;
        timer_d        = timer_q;

        if (jump_en) begin
            pc_d        = jump_addr;
            cmd_valid_d = 1'b0;
            mem_rd_d    = 1'b0;
            fetch_err_d = 1'b0;
            timer_d     = {TW{1'b0}};
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        mem_addr_d = pc_q;
                        mem_rd_d   = 1'b1;
                        timer_d    = {TW{1'b0}};
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Acks arriving while no read is outstanding belong to an aborted read.
                    if (mem_ack && mem_rd_q) begin
                        command_word_d = mem_data;
                        cmd_pc_d       = pc_q;
                        pc_d           = pc_q + ADDR_BITS'(1);
                        cmd_valid_d    = 1'b1;
                        mem_rd_d       = 1'b0;
                        state_d        = ST_HOLD;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        mem_rd_d    = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = ST_ERR;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        if (run) begin
                            mem_addr_d = pc_q;
                            mem_rd_d   = 1'b1;
                            timer_d    = {TW{1'b0}};
                            state_d    = ST_WAIT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_ERR: begin
                    mem_rd_d    = 1'b0;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_ERR;
                end
                default: begin
                    mem_rd_d    = 1'b0;
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            mem_addr_q     <= {ADDR_BITS{1'b0}};
            mem_rd_q       <= 1'b0;
            command_word_q <= 32'h0000_0000;
            cmd_pc_q       <= {ADDR_BITS{1'b0}};
            cmd_valid_q    <= 1'b0;
            fetch_err_q    <= 1'b0;
            timer_q        <= {TW{1'b0}};
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            mem_addr_q     <= mem_addr_d;
            mem_rd_q       <= mem_rd_d;
            command_word_q <= command_word_d;
            cmd_pc_q       <= cmd_pc_d;
            cmd_valid_q    <= cmd_valid_d;
            fetch_err_q    <= fetch_err_d;
            timer_q        <= timer_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign command_word = command_word_q;
    assign cmd_pc       = cmd_pc_q;
    assign cmd_valid    = cmd_valid_q;
    assign pc           = pc_q;
    assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_command_fetch.sv
// Directed bench for command_fetch: hand-computed expectations, sampled 1 time unit
// after each rising edge, inputs driven right after sampling.
module tb_command_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] command_word;
    logic [31:0] cmd_pc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] pc;
    logic        fetch_err;

    int n_cmp  = 0;
    int n_fail = 0;

    command_fetch #(.ADDR_BITS(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
        .command_word(command_word), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        mem_data = 32'h0; mem_ack = 1'b0; cmd_ready = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({mem_rd, cmd_valid, fetch_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {mem_rd, cmd_valid, fetch_err});
        end
        n_cmp++;
        if ({mem_addr, command_word, cmd_pc, pc} !== 128'h0) begin
            n_fail++; $display("FAIL reset_values got %h want 0", {mem_addr, command_word, cmd_pc, pc});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_run got mem_rd=%b want 0", mem_rd);
        end
    endtask

    task automatic test_first_fetch();
        run = 1'b1;
        tick();
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req got rd=%b addr=%h want 1/0", mem_rd, mem_addr);
        end
        mem_ack = 1'b1; mem_data = 32'hA000_1234;
        tick();
        mem_ack = 1'b0; mem_data = 32'h0;
        n_cmp++;
        if (cmd_valid !== 1'b1 || command_word !== 32'hA000_1234 || cmd_pc !== 32'h0 || pc !== 32'h1 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL first_word got v=%b w=%h cpc=%h pc=%h rd=%b want 1/a0001234/0/1/0",
                               cmd_valid, command_word, cmd_pc, pc, mem_rd);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (cmd_valid !== 1'b1 || command_word !== 32'hA000_1234 || cmd_pc !== 32'h0 || mem_rd !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%b w=%h cpc=%h rd=%b want 1/a0001234/0/0",
                                   i, cmd_valid, command_word, cmd_pc, mem_rd);
            end
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++;
        if (cmd_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 32'h1) begin
            n_fail++; $display("FAIL stall_accept got v=%b rd=%b addr=%h want 0/1/1", cmd_valid, mem_rd, mem_addr);
        end
    endtask

    task automatic test_jump_restart();
        jump_en = 1'b1; jump_addr = 32'h0;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL jump_abort got rd=%b pc=%h want 0/0", mem_rd, pc);
        end
        tick();
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL jump_refetch got rd=%b addr=%h want 1/0", mem_rd, mem_addr);
        end
    endtask

    task automatic test_sequential();
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_data = 32'h10 + 32'(i);
            tick();
            mem_ack = 1'b0;
            n_cmp++;
            if (cmd_valid !== 1'b1 || command_word !== 32'h10 + 32'(i) || cmd_pc !== 32'(i)) begin
                n_fail++; $display("FAIL seq_word[%0d] got v=%b w=%h cpc=%h want 1/%h/%h",
                                   i, cmd_valid, command_word, cmd_pc, 32'h10 + 32'(i), i);
            end
            tick();
            n_cmp++;
            if (mem_rd !== 1'b1 || mem_addr !== 32'(i + 1) || cmd_valid !== 1'b0) begin
                n_fail++; $display("FAIL seq_next[%0d] got rd=%b addr=%h v=%b want 1/%h/0",
                                   i, mem_rd, mem_addr, cmd_valid, i + 1);
            end
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (mem_rd !== 1'b1 || fetch_err !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early got early=%b want 0", early);
        end
        tick();
        n_cmp++;
        if (fetch_err !== 1'b1 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL timeout_edge got err=%b rd=%b want 1/0", fetch_err, mem_rd);
        end
        tick(); tick();
        n_cmp++;
        if (fetch_err !== 1'b1 || mem_rd !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_sticky got err=%b rd=%b v=%b want 1/0/0", fetch_err, mem_rd, cmd_valid);
        end
        jump_en = 1'b1; jump_addr = 32'h40;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (fetch_err !== 1'b0 || pc !== 32'h40) begin
            n_fail++; $display("FAIL err_clear got err=%b pc=%h want 0/40", fetch_err, pc);
        end
        tick();
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL err_refetch got rd=%b addr=%h want 1/40", mem_rd, mem_addr);
        end
    endtask

    task automatic test_jump_vs_ack();
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; jump_en = 1'b1; jump_addr = 32'h80;
        tick();
        jump_en = 1'b0;
        n_cmp++;
        if (cmd_valid !== 1'b0 || pc !== 32'h80 || mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL jump_ack got v=%b pc=%h rd=%b want 0/80/0", cmd_valid, pc, mem_rd);
        end
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (cmd_valid !== 1'b0 || pc !== 32'h80 || mem_rd !== 1'b1 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL stale_ack got v=%b pc=%h rd=%b addr=%h want 0/80/1/80",
                               cmd_valid, pc, mem_rd, mem_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFF;
        tick();
        jump_en = 1'b0;
        tick();
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_req got rd=%b addr=%h want 1/ffffffff", mem_rd, mem_addr);
        end
        mem_ack = 1'b1; mem_data = 32'h0000_55AA;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (pc !== 32'h0 || cmd_pc !== 32'hFFFF_FFFF || command_word !== 32'h0000_55AA) begin
            n_fail++; $display("FAIL wrap_pc got pc=%h cpc=%h w=%h want 0/ffffffff/000055aa", pc, cmd_pc, command_word);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next got rd=%b addr=%h want 1/0", mem_rd, mem_addr);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({mem_rd, cmd_valid, fetch_err} !== 3'b000 || {mem_addr, command_word, cmd_pc, pc} !== 128'h0) begin
            n_fail++; $display("FAIL reset_in_wait got flags=%b vals=%h want 000/0",
                               {mem_rd, cmd_valid, fetch_err}, {mem_addr, command_word, cmd_pc, pc});
        end
        rst_n = 1'b1; run = 1'b0;
        tick();
        n_cmp++;
        if (mem_rd !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got rd=%b v=%b want 0/0", mem_rd, cmd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_jump_restart();
        test_sequential();
        test_timeout();
        test_jump_vs_ack();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
